oven_display_mux: RTL and testbench

- Downstream consumer of the oven time-of-day counter.
- Takes the four BCD digits (hours tens/ones, minutes tens/ones) and drives a common-anode 4-digit 7-segment display by time-multiplexing.
- Adds the following display features:
  - frame-coherent digit snapshot, so no tearing mid-scan;
  - leading-zero blanking on the hours-tens digit;
  - a 1 Hz blinking colon;
  - ghost-suppression guard time between digits.

---
 rtl/oven_pkg.sv | 34 +++
 rtl/oven_display_mux_bcd_to_seg7.sv | 28 ++
 rtl/oven_display_mux.sv | 167 ++++++++++++++++
 tb/tb_oven_display_mux.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/oven_pkg.sv
// Shared constants for the oven display blocks: segment glyphs
// (active-low {g,f,e,d,c,b,a}) and the digit slot numbering.
package oven_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    localparam logic [1:0] D_MIN_ONES  = 2'd0;
    localparam logic [1:0] D_MIN_TENS  = 2'd1;
    localparam logic [1:0] D_HOUR_ONES = 2'd2;
    localparam logic [1:0] D_HOUR_TENS = 2'd3;

    // The scan state is the digit slot currently being driven.
    typedef enum logic [1:0] {
        SLOT_D0 = D_MIN_ONES,
        SLOT_D1 = D_MIN_TENS,
        SLOT_D2 = D_HOUR_ONES,
        SLOT_D3 = D_HOUR_TENS
    } slot_e;

endpackage

// File: rtl/oven_display_mux_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder (active-low). Codes 10-15 are not
// valid BCD and show a dash so a corrupted digit is visible on the panel.
import oven_pkg::*;

module bcd_to_seg7 (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Glyph lookup with dash fallback for non-BCD codes.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/oven_display_mux.sv
// Time-multiplexed driver for a common-anode 4-digit 7-segment display.
// Digits are snapshotted once per frame so a time-of-day rollover never tears
// across a scan; each slot opens with a guard period with all anodes off to
// suppress ghosting; hours-tens is blanked when zero; the colon blinks.
import oven_pkg::*;

module oven_display_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       disp_en,
    input  logic [3:0] hour_tens,
    input  logic [3:0] hour_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int SLOT_W  = $clog2(REFRESH_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    slot_e               state, state_next;
    logic [SLOT_W-1:0]   slot_cnt, slot_cnt_next;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                colon_phase;
    logic                first_cycle;
    logic                disp_en_q;
    logic [3:0]          snap_ht, snap_ho, snap_mt, snap_mo;

    logic                slot_last;
    logic                in_guard;
    logic                snap_take;
    logic [3:0]          cur_digit;
    logic [6:0]          dec_seg;
    logic [6:0]          seg_next;
    logic [3:0]          an_next;
    logic                dp_next;

    assign slot_last = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
    assign in_guard  = (slot_cnt <  SLOT_W'(GUARD));

    // Latch a fresh frame after reset, on display enable, and at each 3->0 wrap.
    assign snap_take = first_cycle
                    || (disp_en && !disp_en_q)
                    || (disp_en && slot_last && (state == SLOT_D3));

    // Scan state register: current digit slot and position within the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SLOT_D0;
            slot_cnt <= '0;
        end else begin
            state    <= state_next;
            slot_cnt <= slot_cnt_next;
        end
    end

    // Next-state: count through the slot, step the digit on wrap, park when dark.
    always_comb begin
        state_next    = state;
        slot_cnt_next = slot_cnt;
        if (!disp_en) begin
            state_next    = SLOT_D0;
            slot_cnt_next = '0;
        end else if (slot_last) begin
            slot_cnt_next = '0;
            case (state)
                SLOT_D0: state_next = SLOT_D1;
                SLOT_D1: state_next = SLOT_D2;
                SLOT_D2: state_next = SLOT_D3;
                default: state_next = SLOT_D0;
            endcase
        end else begin
            slot_cnt_next = slot_cnt + 1'b1;
        end
    end

    // Frame snapshot plus edge/first-cycle bookkeeping for when to take it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_ht     <= 4'd0;
            snap_ho     <= 4'd0;
            snap_mt     <= 4'd0;
            snap_mo     <= 4'd0;
            first_cycle <= 1'b1;
            disp_en_q   <= 1'b0;
        end else begin
            first_cycle <= 1'b0;
            disp_en_q   <= disp_en;
            if (snap_take) begin
                snap_ht <= hour_tens;
                snap_ho <= hour_ones;
                snap_mt <= min_tens;
                snap_mo <= min_ones;
            end
        end
    end

    // Colon half-period timer; free-running regardless of disp_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            colon_phase <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            colon_phase <= ~colon_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Pick the snapshot digit belonging to the current slot.
    always_comb begin
        cur_digit = snap_mo;
        case (state)
            SLOT_D0: cur_digit = snap_mo;
            SLOT_D1: cur_digit = snap_mt;
            SLOT_D2: cur_digit = snap_ho;
            SLOT_D3: cur_digit = snap_ht;
            default: cur_digit = snap_mo;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // Output pattern for the current slot: guard, leading-zero blank, colon.
    always_comb begin
        an_next  = 4'b1111;
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        if (disp_en) begin
            seg_next = ((state == SLOT_D3) && (snap_ht == 4'd0)) ? SEG_BLANK : dec_seg;
            if (!in_guard) begin
                case (state)
                    SLOT_D0: an_next = 4'b1110;
                    SLOT_D1: an_next = 4'b1101;
                    SLOT_D2: an_next = 4'b1011;
                    SLOT_D3: an_next = 4'b0111;
                    default: an_next = 4'b1111;
                endcase
                dp_next = !((state == SLOT_D2) && colon_phase);
            end
        end
    end

    // Registered display outputs so anode and segment change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_oven_display_mux.sv
// Directed bench for oven_display_mux with a short refresh/guard/blink setup.
// Outputs are sampled on the falling edge; bp tracks which cycle after reset
// release the next sampled output reflects, which fixes the colon phase.
module tb_oven_display_mux;

  logic       clk;
  logic       rst;
  logic       disp_en;
  logic [3:0] hour_tens, hour_ones, min_tens, min_ones;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int tests_run;
  int tests_failed;
  int bp;

  oven_display_mux #(
    .REFRESH_DIV (8),
    .GUARD       (2),
    .BLINK_DIV   (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .disp_en   (disp_en),
    .hour_tens (hour_tens),
    .hour_ones (hour_ones),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    bp++;
  endtask

  // Hand-entered glyph table, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // One full digit slot (8 cycles): 2 guard cycles, then the digit lit.
  task automatic check_slot(input int d, input logic [6:0] exp_seg);
    logic [3:0] exp_an;
    logic       exp_dp;
    case (d)
      0:       exp_an = 4'b1110;
      1:       exp_an = 4'b1101;
      2:       exp_an = 4'b1011;
      default: exp_an = 4'b0111;
    endcase
    for (int s = 0; s < 8; s++) begin
      int p;
      p = bp;
      tick();
      exp_dp = (d == 2 && s >= 2 && ((p / 20) % 2 == 1)) ? 1'b0 : 1'b1;
      if (s < 2) begin
        chk($sformatf("d%0d_s%0d_guard_an", d, s), 7'(an), 7'(4'b1111));
      end else begin
        chk($sformatf("d%0d_s%0d_an", d, s), 7'(an), 7'(exp_an));
        chk($sformatf("d%0d_s%0d_seg", d, s), seg, exp_seg);
      end
      chk($sformatf("d%0d_s%0d_dp", d, s), 7'(dp), 7'(exp_dp));
    end
  endtask

  task automatic check_frame(input logic [3:0] ht, ho, mt, mo);
    check_slot(0, glyph(mo));
    check_slot(1, glyph(mt));
    check_slot(2, glyph(ho));
    check_slot(3, (ht == 4'd0) ? 7'b1111111 : glyph(ht));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    bp           = 0;
    rst          = 1'b1;
    disp_en      = 1'b1;
    hour_tens    = 4'd1;
    hour_ones    = 4'd2;
    min_tens     = 4'd3;
    min_ones     = 4'd4;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_an",  7'(an), 7'(4'b1111));
    chk("rst_seg", seg,    7'b1111111);
    chk("rst_dp",  7'(dp), 7'(1'b1));
    rst = 1'b0;
    bp  = 0;

    // 12:34 first frame after reset
    check_frame(4'd1, 4'd2, 4'd3, 4'd4);

    // reset pulsed mid slot D2
    check_slot(0, glyph(4'd4));
    check_slot(1, glyph(4'd3));
    repeat (4) tick();
    chk("pre_rst_an",  7'(an), 7'(4'b1011));
    chk("pre_rst_seg", seg,    7'b0100100);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_an",  7'(an), 7'(4'b1111));
    chk("async_rst_seg", seg,    7'b1111111);
    chk("async_rst_dp",  7'(dp), 7'(1'b1));
    @(negedge clk);
    rst = 1'b0;
    bp  = 0;

    // restart from D0 with guard, then live change 12:34 -> 12:35 during D1
    check_frame(4'd1, 4'd2, 4'd3, 4'd4);
    check_slot(0, glyph(4'd4));
    min_ones = 4'd5;
    check_slot(1, glyph(4'd3));
    check_slot(2, glyph(4'd2));
    check_slot(3, glyph(4'd1));
    check_frame(4'd1, 4'd2, 4'd3, 4'd5);

    // disp_en dropped while D1 is lit
    check_slot(0, glyph(4'd5));
    repeat (3) tick();
    chk("pre_dis_an", 7'(an), 7'(4'b1101));
    disp_en   = 1'b0;
    hour_tens = 4'd0;
    hour_ones = 4'd9;
    min_tens  = 4'd3;
    min_ones  = 4'hC;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("dis%0d_an", i),  7'(an), 7'(4'b1111));
      chk($sformatf("dis%0d_seg", i), seg,    7'b1111111);
      chk($sformatf("dis%0d_dp", i),  7'(dp), 7'(1'b1));
    end

    // re-enable: snapshot 09:3C, scan restarts at D0 with guard;
    // D3 lit but blank, D2 shows 9, D0 shows dash
    disp_en = 1'b1;
    check_frame(4'd0, 4'd9, 4'd3, 4'hC);
    check_frame(4'd0, 4'd9, 4'd3, 4'hC);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
